m_root_move_scheduler: RTL

Root-level move scheduler for the AI turn: on a start pulse it snapshots the board, walks the seven columns in centre-out order, skips full columns, and sends each legal column to a shared subtree evaluator through a start/done handshake. It keeps the best score and reports the chosen column with a one-cycle done pulse. It sits between the game controller (start/abort) and the evaluator (`m_game_tree` instance at depth N-1), which it controls exclusively.

---
 rtl/m_root_move_scheduler_if.sv | 25 ++
 rtl/m_root_move_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/m_root_move_scheduler_if.sv
// Evaluator-side bundle of the root move scheduler: request/column/snapshot out,
// done/score back. The scheduler owns the master side.
interface m_root_move_scheduler_if #(
  parameter int NUM_COLS = 7,
  parameter int ROWS     = 6,
  parameter int SCORE_W  = 16
);
  logic                        o_eval_start;
  logic [2:0]                  o_eval_col;
  logic [NUM_COLS*ROWS-1:0]    o_me_field;
  logic [NUM_COLS*ROWS-1:0]    o_op_field;
  logic [3*NUM_COLS-1:0]       o_piled_array;
  logic                        i_eval_done;
  logic signed [SCORE_W-1:0]   i_eval_score;

  modport master (
    output o_eval_start, o_eval_col, o_me_field, o_op_field, o_piled_array,
    input  i_eval_done, i_eval_score
  );

  modport slave (
    input  o_eval_start, o_eval_col, o_me_field, o_op_field, o_piled_array,
    output i_eval_done, i_eval_score
  );
endinterface

// File: rtl/m_root_move_scheduler.sv
// Root move scheduler: snapshots the board, offers each legal column to the
// subtree evaluator in centre-out order and reports the best-scoring column.
module m_root_move_scheduler #(
  parameter int NUM_COLS = 7,
  parameter int ROWS     = 6,
  parameter int SCORE_W  = 16
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [NUM_COLS*ROWS-1:0]   i_me_field,
  input  logic [NUM_COLS*ROWS-1:0]   i_op_field,
  input  logic [3*NUM_COLS-1:0]      i_piled_array,
  m_root_move_scheduler_if.master    eval,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [2:0]                 o_selected_col,
  output logic signed [SCORE_W-1:0]  o_best_score,
  output logic                       o_no_move
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] ROWS_L   = 3'(ROWS);
  localparam logic [2:0] LAST_IDX = 3'(NUM_COLS - 1);
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [NUM_COLS*ROWS-1:0] me_q, op_q;
  logic [3*NUM_COLS-1:0]    piled_q;
  logic                     eval_start_q;
  logic [2:0]               eval_col_q;
  logic [2:0]               idx_q;
  logic                     found_q;
  logic signed [SCORE_W-1:0] best_q;
  logic [2:0]               best_col_q;
  logic [2:0]               sel_q;
  logic signed [SCORE_W-1:0] best_score_q;
  logic                     no_move_q;

  logic                     load, launch, advance, take, finish;
  logic [2:0]               scan_col, scan_cnt;
  logic                     scan_full;
  logic signed [SCORE_W-1:0] best_d;
  logic [2:0]               best_col_d;
  logic                     found_d;

  function automatic logic [2:0] order_col(input logic [2:0] idx);
    case (idx)
      3'd0:    order_col = 3'd3;
      3'd1:    order_col = 3'd2;
      3'd2:    order_col = 3'd4;
      3'd3:    order_col = 3'd1;
      3'd4:    order_col = 3'd5;
      3'd5:    order_col = 3'd0;
      3'd6:    order_col = 3'd6;
      default: order_col = 3'd0;
    endcase
  endfunction

  assign scan_col  = order_col(idx_q);
  assign scan_cnt  = piled_q[3*scan_col +: 3];
  assign scan_full = (scan_cnt >= ROWS_L);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The result written at DONE entry must include the last evaluator answer,
  // so the best-so-far update is computed here and shared with the result path.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    launch  = 1'b0;
    advance = 1'b0;
    take    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d = S_SCAN;
          load    = 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_full) begin
          advance = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
          launch  = 1'b1;
        end
      end
      S_WAIT: begin
        if (eval.i_eval_done && !eval_start_q) begin
          take    = !found_q || (eval.i_eval_score > best_q);
          advance = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && i_abort) begin
      state_d = S_IDLE;
      launch  = 1'b0;
      advance = 1'b0;
      take    = 1'b0;
      finish  = 1'b0;
    end
    best_d     = take ? eval.i_eval_score : best_q;
    best_col_d = take ? eval_col_q : best_col_q;
    found_d    = found_q | take;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      me_q         <= '0;
      op_q         <= '0;
      piled_q      <= '0;
      eval_start_q <= 1'b0;
      eval_col_q   <= 3'd0;
      idx_q        <= 3'd0;
      found_q      <= 1'b0;
      best_q       <= '0;
      best_col_q   <= 3'd0;
      sel_q        <= 3'd0;
      best_score_q <= '0;
      no_move_q    <= 1'b0;
    end else begin
      eval_start_q <= launch;
      if (launch) eval_col_q <= scan_col;
      if (load) begin
        me_q       <= i_me_field;
        op_q       <= i_op_field;
        piled_q    <= i_piled_array;
        idx_q      <= 3'd0;
        found_q    <= 1'b0;
        best_q     <= '0;
        best_col_q <= 3'd0;
      end else begin
        if (advance) idx_q <= idx_q + 3'd1;
        best_q     <= best_d;
        best_col_q <= best_col_d;
        found_q    <= found_d;
      end
      if (finish) begin
        sel_q        <= found_d ? best_col_d : 3'd0;
        best_score_q <= found_d ? best_d : MOST_NEG;
        no_move_q    <= !found_d;
      end
    end
  end

  assign eval.o_eval_start  = eval_start_q;
  assign eval.o_eval_col    = eval_col_q;
  assign eval.o_me_field    = me_q;
  assign eval.o_op_field    = op_q;
  assign eval.o_piled_array = piled_q;

  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_selected_col = sel_q;
  assign o_best_score   = best_score_q;
  assign o_no_move      = no_move_q;

endmodule
